// File: rtl/elastic_compute_pipeline.sv
// DEPTH stages of f(x)=3x+1 plus an x2 output slot; DEPTH+1 cycles latency, 1 word/cycle, combinational ready chain.
// Optional stall counter port stall_cycles is built only when ELASTIC_PIPE_STATS_EN is defined.
module elastic_compute_pipeline #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
`ifdef ELASTIC_PIPE_STATS_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam int D = DEPTH;

  logic [D:0]       valid;
  logic [D:0]       ready;
  logic [D:0]       move;
  logic [D:0]       load;
  logic [WIDTH-1:0] data [D+1];
  logic             accept;

  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] x);
    return (x << 1) + (x + WIDTH'(1));
  endfunction

  // Ready ripples from the output slot back to the input in one cycle.
  always_comb begin
    ready = '0;
    move  = '0;
    move[D]  = valid[D] && out_ready;
    ready[D] = !valid[D] || out_ready;
    for (int k = D - 1; k >= 0; k--) begin
      move[k]  = valid[k] && ready[k+1];
      ready[k] = !valid[k] || move[k];
    end
  end

  assign in_ready  = ready[0] && !flush && !rst;
  assign accept    = in_valid && in_ready;
  assign load      = {move[D-1:0], accept};
  assign out_valid = valid[D];
  assign out_data  = data[D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= '0;
      occupancy <= '0;
      for (int k = 0; k <= D; k++) data[k] <= '0;
    end else begin
      if (load[0]) data[0] <= f_step(in_data);
      for (int k = 1; k < D; k++) begin
        if (load[k]) data[k] <= f_step(data[k-1]);
      end
      if (load[D]) data[D] <= data[D-1] << 1;

      // Flush drops the valid bits only; data registers keep whatever they held.
      if (flush) begin
        valid     <= '0;
        occupancy <= '0;
      end else begin
        valid <= load | (valid & ~move);
        if (accept && !move[D])
          occupancy <= occupancy + CNT_W'(1);
        else if (!accept && move[D])
          occupancy <= occupancy - CNT_W'(1);
      end
    end
  end

`ifdef ELASTIC_PIPE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (flush)
      stall_cycles <= '0;
    else if (valid[D] && !out_ready && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_elastic_compute_pipeline.sv
// Directed bench for elastic_compute_pipeline: an 8x8 instance for latency/backpressure/flush/reset
// and a 16x3 instance under random valid/ready toggling, both against a queue scoreboard.
module tb_elastic_compute_pipeline;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, DEPTH=8
  logic       a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic       a_in_ready, a_out_valid;
  logic [7:0] a_in_data = 8'd0, a_out_data, a_occ;
`ifdef ELASTIC_PIPE_STATS_EN
  logic [31:0] a_stall, b_stall;
`endif

  // Instance B: WIDTH=16, DEPTH=3
  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic        b_in_ready, b_out_valid;
  logic [15:0] b_in_data = 16'd0, b_out_data;
  logic [3:0]  b_occ;

  elastic_compute_pipeline #(.WIDTH(8), .DEPTH(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
`ifdef ELASTIC_PIPE_STATS_EN
    , .stall_cycles(a_stall)
`endif
  );

  elastic_compute_pipeline #(.WIDTH(16), .DEPTH(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
`ifdef ELASTIC_PIPE_STATS_EN
    , .stall_cycles(b_stall)
`endif
  );

  int checks = 0;
  int errors = 0;
  int na_out = 0;
  logic [7:0]  qa[$];
  logic [15:0] qb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_a(input logic [7:0] x);
    logic [7:0] v;
    v = x;
    for (int i = 0; i < 8; i++) v = v * 8'd3 + 8'd1;
    return v * 8'd2;
  endfunction

  function automatic logic [15:0] model_b(input logic [15:0] x);
    logic [15:0] v;
    v = x;
    for (int i = 0; i < 3; i++) v = v * 16'd3 + 16'd1;
    return v * 16'd2;
  endfunction

  // One clock of instance A with scoreboard bookkeeping; inputs are set by the caller beforehand.
  task automatic cyc_a(output logic acc);
    logic       mv;
    logic [7:0] di, od;
    #1;
    acc = a_in_valid && a_in_ready;
    mv  = a_out_valid && a_out_ready;
    di  = a_in_data;
    od  = a_out_data;
    @(posedge clk);
    #1;
    if (acc) qa.push_back(model_a(di));
    if (mv) begin
      na_out++;
      if (qa.size() == 0) chk("a_extra_output", 32'd1, 32'd0);
      else chk("a_order", {24'd0, od}, {24'd0, qa.pop_front()});
    end
  endtask

  task automatic drain_a();
    logic acc;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int c = 0; c < 40 && a_occ != 8'd0; c++) cyc_a(acc);
    chk("a_drain_occ", {24'd0, a_occ}, 32'd0);
    chk("a_drain_queue", qa.size(), 32'd0);
  endtask

  initial begin
    logic acc;
    int   n, w, start;

    // Reset values
    #2;
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, a_out_data}, 32'd0);
    chk("rst_occ", {24'd0, a_occ}, 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);

    // Zeros stream: latency DEPTH+1 and first result 160
    a_in_valid = 1'b1; a_in_data = 8'd0; a_out_ready = 1'b1;
    n = 0;
    while (!a_out_valid && n < 20) begin cyc_a(acc); n++; end
    chk("zero_latency", n, 32'd9);
    chk("zero_first_data", {24'd0, a_out_data}, 32'd160);
    for (int i = 0; i < 3; i++) begin
      cyc_a(acc);
      chk("zero_stream_valid", {31'd0, a_out_valid}, 32'd1);
    end
    chk("zero_stream_data", {24'd0, a_out_data}, 32'd160);
    drain_a();

    // Backpressure: offer 1..12 with out_ready low, exactly 9 fit
    a_out_ready = 1'b0;
    w = 1;
    for (int c = 0; c < 15; c++) begin
      a_in_valid = (w <= 12);
      a_in_data  = 8'(w);
      cyc_a(acc);
      if (acc) w++;
    end
    chk("bp_accepted", w - 1, 32'd9);
    chk("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
    chk("bp_occ", {24'd0, a_occ}, 32'd9);
    start = na_out;
    drain_a();
    chk("bp_drained_count", na_out - start, 32'd9);
    for (int c = 0; c < 10 && w <= 12; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(w);
      cyc_a(acc);
      if (acc) w++;
    end
    drain_a();
    chk("bp_total_count", na_out - start, 32'd12);

    // Full pass-through: one leaves, one enters, occupancy stays 9
    a_out_ready = 1'b0;
    for (int c = 0; c < 20 && a_occ != 8'd9; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(100 + c);
      cyc_a(acc);
    end
    a_in_data = 8'd200;
    a_out_ready = 1'b1;
    #1;
    chk("pt_in_ready", {31'd0, a_in_ready}, 32'd1);
    cyc_a(acc);
    chk("pt_accept", {31'd0, acc}, 32'd1);
    chk("pt_occ", {24'd0, a_occ}, 32'd9);
    drain_a();

    // Flush with occupancy 5 and a word offered
    a_out_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(50 + c);
      cyc_a(acc);
      if (acc) n++;
    end
    a_in_valid = 1'b0;
    #1;
    chk("fl_occ_before", {24'd0, a_occ}, 32'd5);
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 8'd77;
    #1;
    chk("fl_in_ready", {31'd0, a_in_ready}, 32'd0);
    cyc_a(acc);
    chk("fl_no_accept", {31'd0, acc}, 32'd0);
    chk("fl_occ", {24'd0, a_occ}, 32'd0);
    chk("fl_out_valid", {31'd0, a_out_valid}, 32'd0);
    a_flush = 1'b0; a_in_valid = 1'b0;
    qa.delete();
    cyc_a(acc);
    chk("fl_occ_after", {24'd0, a_occ}, 32'd0);

`ifdef ELASTIC_PIPE_STATS_EN
    // Stall counter: 20 stalled cycles, then cleared by flush
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'd9;
    cyc_a(acc);
    a_in_valid = 1'b0;
    for (int c = 0; c < 20 && !a_out_valid; c++) cyc_a(acc);
    chk("st_zero_before", a_stall, 32'd0);
    for (int c = 0; c < 20; c++) cyc_a(acc);
    chk("st_count", a_stall, 32'd20);
    a_flush = 1'b1;
    cyc_a(acc);
    a_flush = 1'b0;
    chk("st_flush", a_stall, 32'd0);
    qa.delete();
`endif

    // Random valid/ready toggling on instance B
    begin
      int         nb_in, nb_out;
      logic       bacc, bmv;
      logic [15:0] bdi, bdo;
      nb_in = 0; nb_out = 0;
      for (int c = 0; c < 20000 && nb_out < 1000; c++) begin
        b_in_valid  = (nb_in < 1000) && ($urandom_range(0, 3) != 0);
        b_in_data   = 16'($urandom);
        b_out_ready = ($urandom_range(0, 3) != 0);
        #1;
        bacc = b_in_valid && b_in_ready;
        bmv  = b_out_valid && b_out_ready;
        bdi  = b_in_data;
        bdo  = b_out_data;
        @(posedge clk); #1;
        if (bacc) begin qb.push_back(model_b(bdi)); nb_in++; end
        if (bmv) begin
          nb_out++;
          if (qb.size() == 0) chk("b_extra_output", 32'd1, 32'd0);
          else chk("b_order", {16'd0, bdo}, {16'd0, qb.pop_front()});
        end
        chk("b_occ", {28'd0, b_occ}, qb.size());
      end
      b_in_valid = 1'b0;
      chk("b_in_count", nb_in, 32'd1000);
      chk("b_out_count", nb_out, 32'd1000);
      chk("b_left", qb.size(), 32'd0);
    end

    // Async reset mid-stream
    a_in_valid = 1'b1; a_out_ready = 1'b1; a_in_data = 8'd3;
    for (int c = 0; c < 12; c++) cyc_a(acc);
    chk("ar_out_valid_before", {31'd0, a_out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("ar_out_data", {24'd0, a_out_data}, 32'd0);
    chk("ar_occ", {24'd0, a_occ}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
